// File: rtl/rf_exec_ctrl.sv
// rf_exec_ctrl: multi-cycle execute controller feeding the RFSet register file.
// Each accepted start walks IDLE -> DECODE -> EXEC -> WB -> IDLE and performs
// exactly one write-back. All outputs come straight from flops.
module rf_exec_ctrl #(
  parameter int DW = 4,
  parameter int AW = 2,
  localparam int IW = 2 + 3*AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [IW-1:0] instr,
  input  logic [DW-1:0] A,
  input  logic [DW-1:0] B,
  output logic [AW-1:0] RA,
  output logic [AW-1:0] RB,
  output logic          RE,
  output logic [AW-1:0] WR,
  output logic [DW-1:0] WRD,
  output logic          busy,
  output logic          done,
  output logic          zflag,
  output logic          cflag
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_LDI = 2'b11
  } op_t;

  state_t        state_q, state_d;
  op_t           op_q, op_d;
  logic [AW-1:0] ra_q, ra_d;
  logic [AW-1:0] rb_q, rb_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [DW-1:0] wrd_q, wrd_d;
  logic          re_q, re_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          zflag_q, zflag_d;
  logic          cflag_q, cflag_d;

  logic [DW-1:0] alu_res;
  logic          alu_c;
  logic [DW:0]   sum;

  // ALU; LDI reuses ra_q/rb_q as the immediate since they hold srcA/srcB
  always_comb begin
    sum     = {1'b0, A} + {1'b0, B};
    alu_res = '0;
    alu_c   = 1'b0;
    unique case (op_q)
      OP_ADD: begin
        alu_res = sum[DW-1:0];
        alu_c   = sum[DW];
      end
      OP_SUB: begin
        alu_res = A - B;
        alu_c   = (A < B);
      end
      OP_AND: alu_res = A & B;
      OP_LDI: alu_res = DW'({ra_q, rb_q});
      default: ;
    endcase
  end

  // Next-state and next-output logic for the execute sequence
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    wr_d    = wr_q;
    wrd_d   = wrd_q;
    re_d    = re_q;
    busy_d  = busy_q;
    done_d  = done_q;
    zflag_d = zflag_q;
    cflag_d = cflag_q;
    unique case (state_q)
      IDLE: begin
        done_d = 1'b0;
        if (start) begin
          op_d    = op_t'(instr[IW-1 -: 2]);
          wr_d    = instr[3*AW-1 -: AW];
          ra_d    = instr[2*AW-1 -: AW];
          rb_d    = instr[AW-1:0];
          busy_d  = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        wrd_d   = alu_res;
        zflag_d = (alu_res == '0);
        cflag_d = alu_c;
        re_d    = 1'b1;
        state_d = WB;
      end
      WB: begin
        re_d    = 1'b0;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any instruction in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_ADD;
      ra_q    <= '0;
      rb_q    <= '0;
      wr_q    <= '0;
      wrd_q   <= '0;
      re_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      zflag_q <= 1'b0;
      cflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      wr_q    <= wr_d;
      wrd_q   <= wrd_d;
      re_q    <= re_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      zflag_q <= zflag_d;
      cflag_q <= cflag_d;
    end
  end

  assign RA    = ra_q;
  assign RB    = rb_q;
  assign WR    = wr_q;
  assign WRD   = wrd_q;
  assign RE    = re_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign zflag = zflag_q;
  assign cflag = cflag_q;

endmodule

// File: tb/tb_rf_exec_ctrl.sv
// Directed bench for rf_exec_ctrl with a small RFSet model (combinational read,
// write on the clock edge while RE is high).
module tb_rf_exec_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] instr;
  logic [3:0] A, B;
  logic [1:0] RA, RB, WR;
  logic       RE;
  logic [3:0] WRD;
  logic       busy, done, zflag, cflag;

  logic       rf_clr;
  logic [3:0] rf [4];
  int         re_cnt = 0;

  int n_tests = 0;
  int n_fail  = 0;

  rf_exec_ctrl #(.DW(4), .AW(2)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .instr (instr),
    .A     (A),
    .B     (B),
    .RA    (RA),
    .RB    (RB),
    .RE    (RE),
    .WR    (WR),
    .WRD   (WRD),
    .busy  (busy),
    .done  (done),
    .zflag (zflag),
    .cflag (cflag)
  );

  always #5 clk = ~clk;

  // Register file model
  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 4; i++) rf[i] <= 4'h0;
    end else if (RE) begin
      rf[WR] <= WRD;
    end
  end
  assign A = rf[RA];
  assign B = rf[RB];

  // Count write-back pulses seen at clock edges
  always @(posedge clk) if (RE) re_cnt = re_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one instruction from IDLE and check every cycle through done
  task automatic run_instr(input string nm, input logic [7:0] ins,
                           input logic [3:0] exp_wrd, input logic exp_z, input logic exp_c);
    start = 1'b1;
    instr = ins;
    tick();
    start = 1'b0;
    check({nm, "/dec_busy"}, busy, 1);
    check({nm, "/dec_ra"},   RA,   ins[3:2]);
    check({nm, "/dec_rb"},   RB,   ins[1:0]);
    check({nm, "/dec_wr"},   WR,   ins[5:4]);
    check({nm, "/dec_re"},   RE,   0);
    tick();
    check({nm, "/exe_re"},   RE,   0);
    check({nm, "/exe_busy"}, busy, 1);
    tick();
    check({nm, "/wb_re"},    RE,    1);
    check({nm, "/wb_wr"},    WR,    ins[5:4]);
    check({nm, "/wb_wrd"},   WRD,   exp_wrd);
    check({nm, "/wb_z"},     zflag, exp_z);
    check({nm, "/wb_c"},     cflag, exp_c);
    tick();
    check({nm, "/dn_done"},  done,  1);
    check({nm, "/dn_re"},    RE,    0);
    check({nm, "/dn_busy"},  busy,  0);
    check({nm, "/dn_rf"},    rf[ins[5:4]], exp_wrd);
    check({nm, "/dn_z"},     zflag, exp_z);
    check({nm, "/dn_c"},     cflag, exp_c);
  endtask

  int cnt0;

  initial begin
    reset  = 1'b1;
    rf_clr = 1'b1;
    start  = 1'b0;
    instr  = 8'h00;

    // 1: reset for two cycles
    tick();
    tick();
    reset  = 1'b0;
    rf_clr = 1'b0;
    check("rst_ra",   RA, 0);
    check("rst_rb",   RB, 0);
    check("rst_wr",   WR, 0);
    check("rst_wrd",  WRD, 0);
    check("rst_re",   RE, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_z",    zflag, 0);
    check("rst_c",    cflag, 0);
    tick();
    tick();
    check("rst_nore", re_cnt, 0);
    check("rst_idle", busy, 0);

    // 2: immediate loads
    run_instr("ldi_r1_3", 8'b11_01_00_11, 4'b0011, 1'b0, 1'b0);
    run_instr("ldi_r2_5", 8'b11_10_01_01, 4'b0101, 1'b0, 1'b0);

    // 3: add / subtract with borrow
    run_instr("add_8",  8'b00_00_01_10, 4'b1000, 1'b0, 1'b0);
    run_instr("sub_m2", 8'b01_11_01_10, 4'b1110, 1'b0, 1'b1);

    // 4: carry-out to zero, then AND
    run_instr("ldi_r1_13", 8'b11_01_11_01, 4'b1101, 1'b0, 1'b0);
    run_instr("ldi_r2_3",  8'b11_10_00_11, 4'b0011, 1'b0, 1'b0);
    run_instr("add_wrap",  8'b00_00_01_10, 4'b0000, 1'b1, 1'b1);
    run_instr("and_1",     8'b10_11_01_10, 4'b0001, 1'b0, 1'b0);

    // 5: start held high with a changed instr during the sequence
    start = 1'b1;
    instr = 8'b00_00_01_10;
    tick();
    cnt0  = re_cnt;
    instr = 8'b11_11_11_11;
    check("hold_dec_wr", WR, 2'b00);
    check("hold_dec_ra", RA, 2'b01);
    tick();
    check("hold_exe_ra", RA, 2'b01);
    check("hold_exe_wr", WR, 2'b00);
    tick();
    check("hold_wb_re",  RE, 1);
    check("hold_wb_wr",  WR, 2'b00);
    check("hold_wb_wrd", WRD, 4'b0000);
    tick();
    check("hold_dn_done", done, 1);
    check("hold_dn_busy", busy, 0);
    check("hold_dn_cnt",  re_cnt, cnt0 + 1);
    tick();
    start = 1'b0;
    check("hold2_busy", busy, 1);
    check("hold2_done", done, 0);
    check("hold2_ra",   RA, 2'b11);
    check("hold2_wr",   WR, 2'b11);
    tick();
    tick();
    check("hold2_wb_re",  RE, 1);
    check("hold2_wb_wrd", WRD, 4'b1111);
    tick();
    check("hold2_done2", done, 1);
    check("hold2_cnt",   re_cnt, cnt0 + 2);
    check("hold2_rf3",   rf[3], 4'b1111);

    // 6: reset during EXEC of ADD r0=r3+r1
    start = 1'b1;
    instr = 8'b00_00_11_01;
    tick();
    start = 1'b0;
    tick();
    cnt0 = re_cnt;
    check("mid_exec_busy", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_re",   RE, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_wr",   WR, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    check("mid_rst_cnt",  re_cnt, cnt0);
    check("mid_rst_r0",   rf[0], 4'b0000);
    check("mid_rst_idle", busy, 0);
    check("mid_rst_done", done, 0);
    run_instr("add_after_rst", 8'b00_00_11_01, 4'b1100, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
